// File: rtl/ifb_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Fetch state enum, instruction width, PC alignment mask and sequential PC step.
package ifb_pkg;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } ifb_state_t;

  localparam int          INST_W          = 32;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_STEP         = 32'd4;

endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO holding {inst, pc} entries; head is visible one cycle after push.
// A push is refused when full unless a pop happens in the same cycle; flush beats push.
module ifb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch stage: owns fetch PC, one outstanding imem request, queues words for decode (1-cycle min latency).
// Stops requesting when the queue is full; IFB_BYPASS_EN lets an empty-queue ack reach decode in the ack cycle.
module ifetch_buffer
  import ifb_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  ifb_state_t          state;
  ifb_state_t          state_nxt;
  logic [31:0]         fpc;
  logic [31:0]         addr_q;
  logic                pend_q;
  logic [CW-1:0]       count;
  logic [2*INST_W-1:0] head;
  logic                push;
  logic                pop;
  logic                bypass_vld;
  logic                bypass_take;

  // Address is frozen while a request is outstanding, even after a redirect moves fpc.
  assign imem_addr = pend_q ? addr_q : fpc;
  assign imem_req  = !rst && ((state == DISCARD) || pend_q || (count < FULL_CNT));

`ifdef IFB_BYPASS_EN
  assign bypass_vld = (state == FETCH) && (count == '0) && imem_ack;
`else
  assign bypass_vld = 1'b0;
`endif

  assign bypass_take = bypass_vld && inst_ready && !redirect;
  assign inst_valid  = (count != '0) || (bypass_vld && !redirect);
  assign inst        = bypass_vld ? imem_rdata : head[2*INST_W-1:INST_W];
  assign inst_pc     = bypass_vld ? fpc : head[INST_W-1:0];

  assign push = (state == FETCH) && imem_ack && !redirect && !bypass_take;
  assign pop  = (count != '0) && inst_ready && !redirect;

  ifb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_rdata, fpc}),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (redirect && imem_req && !imem_ack) state_nxt = DISCARD;
      DISCARD: if (imem_ack) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      fpc    <= RESET_PC;
      addr_q <= RESET_PC;
      pend_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= imem_addr;
      pend_q <= imem_req && !imem_ack;
      if (redirect)
        fpc <= redirect_pc & ADDR_ALIGN_MASK;
      else if ((state == FETCH) && imem_ack)
        fpc <= fpc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: cycle table for the first fetches, then a memory model with a
// scoreboard queue of {inst, pc} checked against what decode receives.
module tb_ifetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;

  always #5 clk = ~clk;

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          wcnt = 0;
  int          ack_cnt = 0;
  bit          stale = 0;
  bit          was_pend = 0;
  bit          chk_inval = 0;
  bit          started = 0;
  bit          found = 0;
  bit          first_ack_pending = 1;
  logic        first_ack_valid = 1'b0;
  logic [31:0] exp_fpc = RESET_PC;
  logic [31:0] hold_addr = '0;
  logic [31:0] last_start = '0;
  exp_t        expq[$];
  logic [31:0] got_pcs[$];
  vec_t        tbl[7];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle: drive inputs, answer memory, check outputs against the scoreboard, update model.
  task automatic drive(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy);
    exp_t e;
    bit   exp_v;
    rst = r; redirect = rd; redirect_pc = rpc; inst_ready = rdy;
    imem_ack = 1'b0; imem_rdata = '0;
    started = 0;
    #1;
    if (!r && imem_req && (wcnt == lat)) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end
    #1;
    if (r) begin
      expq.delete(); got_pcs.delete();
      stale = 0; wcnt = 0; was_pend = 0; chk_inval = 0; ack_cnt = 0;
      first_ack_pending = 1;
      exp_fpc = RESET_PC;
    end else begin
      if (was_pend) chk("req_held", {31'b0, imem_req}, 32'd1);
      if (imem_req && wcnt == 0) begin
        started = 1; hold_addr = imem_addr; last_start = imem_addr;
        if (!stale) chk("req_addr", imem_addr, exp_fpc);
      end else if (imem_req) begin
        chk("addr_hold", imem_addr, hold_addr);
      end
      if (chk_inval) chk("valid_after_redirect", {31'b0, inst_valid}, 32'd0);
      chk_inval = 0;
      exp_v = (expq.size() != 0) || (BYP && imem_ack && !stale && !rd);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_v});
      if (imem_ack) begin
        ack_cnt++;
        if (first_ack_pending) begin first_ack_valid = inst_valid; first_ack_pending = 0; end
        if (!stale && !rd) begin e.inst = imem_rdata; e.pc = imem_addr; expq.push_back(e); end
      end
      if (inst_valid && expq.size() != 0) begin
        chk("inst", inst, expq[0].inst);
        chk("inst_pc", inst_pc, expq[0].pc);
        if (rdy && !rd) begin got_pcs.push_back(expq[0].pc); void'(expq.pop_front()); end
      end
      if (rd) begin expq.delete(); got_pcs.delete(); chk_inval = 1; end
      if (rd) exp_fpc = rpc & 32'hFFFF_FFFC;
      else if (imem_ack && !stale) exp_fpc = exp_fpc + 32'd4;
      if (imem_ack) stale = 0;
      else if (rd && imem_req) stale = 1;
      was_pend = imem_req && !imem_ack;
      wcnt = (imem_req && !imem_ack) ? wcnt + 1 : 0;
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    tick();
  endtask

  task automatic wait_start(input logic [31:0] a, input bit rdy);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      drive(1'b0, 1'b0, '0, rdy);
      if (started && last_start == a) found = 1;
      tick();
    end
    chk("wait_start", {31'b0, found}, 32'd1);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b0, '0, rdy);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef IFB_BYPASS_EN
    tbl = '{'{1'b1, 1'b1, 32'h0, 1'b0, 32'h0}, '{1'b1, 1'b1, 32'h0, 1'b1, 32'h0},
            '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0}, '{1'b1, 1'b1, 32'h4, 1'b1, 32'h4},
            '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0}, '{1'b1, 1'b1, 32'h8, 1'b1, 32'h8},
            '{1'b1, 1'b1, 32'hC, 1'b0, 32'h0}};
`else
    tbl = '{'{1'b1, 1'b1, 32'h0, 1'b0, 32'h0}, '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0},
            '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0}, '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0},
            '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4}, '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0},
            '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8}};
`endif
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    @(negedge clk);

    // Zero-wait memory, decode always ready: cycle-exact table.
    lat = 1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, '0, tbl[i].rdy);
      chk("tbl_req", {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk("tbl_addr", imem_addr, tbl[i].addr);
      chk("tbl_valid", {31'b0, inst_valid}, {31'b0, tbl[i].vld});
      if (tbl[i].vld) chk("tbl_pc", inst_pc, tbl[i].pc);
      tick();
    end

    // Stall decode for 20 cycles: queue fills to DEPTH and requests stop.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0);
      if (i == 19) begin
        chk("full_req_low", {31'b0, imem_req}, 32'd0);
        chk("full_valid", {31'b0, inst_valid}, 32'd1);
        chk("full_head_pc", inst_pc, 32'h0);
        chk("full_acks", ack_cnt, DEPTH);
      end
      tick();
    end
    run(16, 1'b1);
    chk("drain_n", {31'b0, got_pcs.size() >= 5}, 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < got_pcs.size()) chk("drain_pc", got_pcs[i], 32'(i * 4));

    // 5-cycle memory, redirect in cycle 2 of the wait on 0x8.
    lat = 5;
    do_reset();
    wait_start(32'h8, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    tick();
    run(40, 1'b1);
    chk("redir_n", {31'b0, got_pcs.size() >= 2}, 32'd1);
    if (got_pcs.size() >= 2) begin
      chk("redir_first_pc", got_pcs[0], 32'h100);
      chk("redir_second_pc", got_pcs[1], 32'h104);
    end

    // Redirect coincident with ack and inst_ready while the queue holds DEPTH-1 words.
    lat = 1;
    do_reset();
    wait_start(32'hC, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    chk("coinc_ack", {31'b0, imem_ack}, 32'd1);
    tick();
    run(12, 1'b1);
    chk("coinc_n", {31'b0, got_pcs.size() >= 1}, 32'd1);
    if (got_pcs.size() >= 1) chk("coinc_first_pc", got_pcs[0], 32'h200);

    // Fetch PC wraps from 0xFFFF_FFFC to 0; low redirect bits are ignored.
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    tick();
    run(16, 1'b1);
    chk("wrap_n", {31'b0, got_pcs.size() >= 2}, 32'd1);
    if (got_pcs.size() >= 2) begin
      chk("wrap_pc0", got_pcs[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", got_pcs[1], 32'h0000_0000);
    end

    // Reset while discarding a stale response; fetch restarts at RESET_PC.
    lat = 5;
    do_reset();
    wait_start(32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1);
    tick();
    drive(1'b1, 1'b0, '0, 1'b1);
    tick();
    drive(1'b1, 1'b0, '0, 1'b1);
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    run(30, 1'b1);
    chk("midrst_n", {31'b0, got_pcs.size() >= 1}, 32'd1);
    if (got_pcs.size() >= 1) chk("midrst_first_pc", got_pcs[0], RESET_PC);
    chk("ack_cycle_valid", {31'b0, first_ack_valid}, {31'b0, BYP});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
